// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern source for the 10101 sequence detector.
// Latches a PAT_W-bit pattern on start and shifts it out MSB first, optionally
// repeating the frame with idle-low gaps between frames. All outputs are registered.
module seq_pattern_tx #(
    parameter int                PAT_W       = 5,
    parameter logic [PAT_W-1:0]  DEFAULT_PAT = 5'b10101,
    parameter int                CNT_W       = 4,
    parameter int                GAP_CYC     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             d_out,
    output logic             valid_out,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PAT_W-1:0]   pat_q, pat_nxt;
    logic [PAT_W-1:0]   shreg, shreg_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [CNT_W-1:0]   frame_cnt, frame_nxt;
    logic               d_nxt, valid_nxt, busy_nxt, done_nxt;
    logic [PAT_W-1:0]   sel_pat;

    assign sel_pat = use_default ? DEFAULT_PAT : pattern;

    // State and datapath registers; outputs are held here so nothing is combinational to a pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pat_q     <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            d_out     <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pat_q     <= pat_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_nxt;
            gap_cnt   <= gap_nxt;
            frame_cnt <= frame_nxt;
            d_out     <= d_nxt;
            valid_out <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state logic: every branch decides what the outputs show during the following cycle.
    always_comb begin
        state_nxt = state;
        pat_nxt   = pat_q;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        frame_nxt = frame_cnt;
        d_nxt     = 1'b0;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE, FIN: begin
                // FIN only lasts one cycle, but a new start may already be accepted in it.
                if (start && !abort) begin
                    state_nxt = SEND;
                    pat_nxt   = sel_pat;
                    frame_nxt = repeat_cnt;
                    shreg_nxt = sel_pat << 1;
                    bit_nxt   = '0;
                    d_nxt     = sel_pat[PAT_W-1];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bit_cnt == LAST_BIT) begin
                    if (frame_cnt != '0) begin
                        frame_nxt = frame_cnt - 1'b1;
                        busy_nxt  = 1'b1;
                        if (GAP_CYC > 0) begin
                            state_nxt = GAP;
                            gap_nxt   = '0;
                        end else begin
                            // Back-to-back frames: reload from the latched copy, no bubble.
                            shreg_nxt = pat_q << 1;
                            bit_nxt   = '0;
                            d_nxt     = pat_q[PAT_W-1];
                            valid_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = FIN;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    d_nxt     = shreg[PAT_W-1];
                    shreg_nxt = shreg << 1;
                    bit_nxt   = bit_cnt + 1'b1;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end

            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (gap_cnt == LAST_GAP) begin
                    state_nxt = SEND;
                    shreg_nxt = pat_q << 1;
                    bit_nxt   = '0;
                    d_nxt     = pat_q[PAT_W-1];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end else begin
                    gap_nxt  = gap_cnt + 1'b1;
                    busy_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
